// File: rtl/ppu_oam_dma_pkg.sv
// Shared constants and state encoding for the sprite OAM DMA initiator.
// Bus addresses are fixed by the CPU memory map: $4014 starts a copy and $2004 receives each byte.
package ppu_oam_dma_pkg;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA: snoops $4014 writes, halts the CPU and copies one page to $2004.
// Outputs are Moore (one clk after each cpu_cken_in pulse); cpu_cken_in low stalls everything.
module ppu_oam_dma
    import ppu_oam_dma_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_cken_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  mem_d_in,
    output logic        active_out,
    output logic        cpu_rdy_out,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        r_nw_out
);

    dma_state_t q_state, d_state;
    logic [7:0] q_page,  d_page;
    logic [7:0] q_cnt,   d_cnt;
    logic [7:0] q_data,  d_data;
    logic       q_par;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q_state <= ST_IDLE;
            q_page  <= 8'h00;
            q_cnt   <= 8'h00;
            q_data  <= 8'h00;
            q_par   <= 1'b0;
        end else if (cpu_cken_in) begin
            q_state <= d_state;
            q_page  <= d_page;
            q_cnt   <= d_cnt;
            q_data  <= d_data;
            q_par   <= ~q_par;
        end
    end

    always_comb begin
        d_state     = q_state;
        d_page      = q_page;
        d_cnt       = q_cnt;
        d_data      = q_data;
        active_out  = 1'b0;
        cpu_rdy_out = 1'b1;
        a_out       = 16'h0000;
        d_out       = 8'h00;
        r_nw_out    = 1'b1;

        unique case (q_state)
            ST_IDLE: begin
                if (!cpu_r_nw_in && (cpu_a_in == DMA_TRIG_ADDR)) begin
                    d_page  = cpu_d_in;
                    d_cnt   = 8'h00;
                    d_state = ST_HALT;
                end
            end
            ST_HALT: begin
                active_out  = 1'b1;
                cpu_rdy_out = 1'b0;
                // An even HALT cycle would put the first read on an odd cycle.
                d_state     = q_par ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                active_out  = 1'b1;
                cpu_rdy_out = 1'b0;
                d_state     = ST_READ;
            end
            ST_READ: begin
                active_out  = 1'b1;
                cpu_rdy_out = 1'b0;
                a_out       = {q_page, q_cnt};
                d_data      = mem_d_in;
                d_state     = ST_WRITE;
            end
            ST_WRITE: begin
                active_out  = 1'b1;
                cpu_rdy_out = 1'b0;
                a_out       = OAM_DATA_ADDR;
                d_out       = q_data;
                r_nw_out    = 1'b0;
                if (q_cnt == 8'hFF) begin
                    d_state = ST_IDLE;
                end else begin
                    d_cnt   = q_cnt + 8'd1;
                    d_state = ST_READ;
                end
            end
            default: begin
                d_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomized bench for ppu_oam_dma against a cycle-indexed model of the transfer schedule.
module tb_ppu_oam_dma;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        cpu_cken_in = 1'b0;
    logic [15:0] cpu_a_in = 16'h0000;
    logic [7:0]  cpu_d_in = 8'h00;
    logic        cpu_r_nw_in = 1'b1;
    logic [7:0]  mem_d_in;
    logic        active_out;
    logic        cpu_rdy_out;
    logic [15:0] a_out;
    logic [7:0]  d_out;
    logic        r_nw_out;

    int total = 0;
    int bad = 0;

    // model state: cycle index since reset, trigger cycle (-1 = none) and page
    int          cyc = 0;
    int          trig = -1;
    logic [7:0]  trig_page = 8'h00;
    int          halted_cnt = 0;
    int          wr_cnt = 0;

    localparam logic [31:0] IDLE_VEC = {5'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00};

    ppu_oam_dma dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cpu_cken_in (cpu_cken_in),
        .cpu_a_in    (cpu_a_in),
        .cpu_d_in    (cpu_d_in),
        .cpu_r_nw_in (cpu_r_nw_in),
        .mem_d_in    (mem_d_in),
        .active_out  (active_out),
        .cpu_rdy_out (cpu_rdy_out),
        .a_out       (a_out),
        .d_out       (d_out),
        .r_nw_out    (r_nw_out)
    );

    always #10 clk_in = ~clk_in;

    // memory: byte at any address = low address byte XOR A5
    assign mem_d_in = a_out[7:0] ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {5'b0, active_out, cpu_rdy_out, r_nw_out, a_out, (r_nw_out ? 8'h00 : d_out)};
    endfunction

    function automatic int first_read(input int t);
        return t + (((t % 2) == 0) ? 2 : 3);
    endfunction

    // expected bus outputs during cycle c, from the schedule rules
    function automatic logic [31:0] exp_out(input int c);
        int fr, k;
        logic [7:0] i;
        if (trig < 0 || c <= trig) return IDLE_VEC;
        fr = first_read(trig);
        if (c > fr + 511) return IDLE_VEC;
        if (c < fr) return {5'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00};
        k = c - fr;
        i = 8'(k / 2);
        if ((k % 2) == 0) return {5'b0, 1'b1, 1'b0, 1'b1, trig_page, i, 8'h00};
        return {5'b0, 1'b1, 1'b0, 1'b0, 16'h2004, i ^ 8'hA5};
    endfunction

    function automatic logic busy(input int c);
        logic [31:0] v;
        v = exp_out(c);
        return v[26];
    endfunction

    task automatic run_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                             input int gap, input string tag);
        cpu_a_in    = a;
        cpu_d_in    = d;
        cpu_r_nw_in = rnw;
        for (int g = 0; g <= gap; g++) begin
            @(negedge clk_in);
            chk(tag, dut_vec(), exp_out(cyc));
        end
        if (!cpu_rdy_out) halted_cnt++;
        if (!r_nw_out) wr_cnt++;
        cpu_cken_in = 1'b1;
        @(negedge clk_in);
        cpu_cken_in = 1'b0;
        if (!busy(cyc) && !rnw && a == 16'h4014) begin
            trig      = cyc;
            trig_page = d;
        end
        cyc++;
    endtask

    task automatic run_idle(input int n, input string tag);
        logic [15:0] a;
        for (int j = 0; j < n; j++) begin
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4015;
            run_cycle(a, 8'($urandom), 1'($urandom), 0, tag);
        end
    endtask

    // random CPU activity (including stray $4014 writes) until the model says the copy is over
    task automatic run_transfer(input int gap_at, input string tag);
        int n;
        logic [15:0] a;
        n = 0;
        while (busy(cyc) && n < 700) begin
            a = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
            run_cycle(a, 8'($urandom), 1'($urandom), (cyc == gap_at) ? 20 : 0, tag);
            n++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        chk("async_rst", dut_vec(), IDLE_VEC);
        @(negedge clk_in);
        rst_in = 1'b0;
        cyc  = 0;
        trig = -1;
    endtask

    initial begin
        #1;
        chk("rst_hold", dut_vec(), IDLE_VEC);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_release", dut_vec(), IDLE_VEC);

        // even trigger: page 02 written on cycle 10
        run_idle(10, "even_idle");
        halted_cnt = 0;
        run_cycle(16'h4014, 8'h02, 1'b0, 0, "even_trig");
        run_transfer(-1, "even_xfer");
        run_idle(2, "even_after");
        chk("even_len", 32'(halted_cnt), 32'd513);

        // odd trigger: page 07 written on cycle 11
        do_reset();
        run_idle(11, "odd_idle");
        halted_cnt = 0;
        run_cycle(16'h4014, 8'h07, 1'b0, 0, "odd_trig");
        run_transfer(-1, "odd_xfer");
        run_idle(2, "odd_after");
        chk("odd_len", 32'(halted_cnt), 32'd514);

        // a read of $4014 must not start anything
        halted_cnt = 0;
        run_cycle(16'h4014, 8'h55, 1'b1, 0, "rd4014");
        run_idle(4, "rd4014_after");
        chk("rd4014_len", 32'(halted_cnt), 32'd0);

        // page FF data path with a 20-clk stall inside a READ cycle
        wr_cnt = 0;
        run_cycle(16'h4014, 8'hFF, 1'b0, 0, "ff_trig");
        run_transfer(first_read(trig) + 40, "ff_xfer");
        run_idle(2, "ff_after");
        chk("ff_writes", 32'(wr_cnt), 32'd256);

        // reset aborts mid-transfer at the read of byte 0x40
        run_cycle(16'h4014, 8'h3C, 1'b0, 0, "abort_trig");
        while (busy(cyc) && cyc != first_read(trig) + 8'h80)
            run_cycle(16'($urandom), 8'($urandom), 1'b1, 0, "abort_xfer");
        @(negedge clk_in);
        chk("abort_pre", dut_vec(), {5'b0, 1'b1, 1'b0, 1'b1, 16'h3C40, 8'h00});
        do_reset();
        run_idle(2, "restart_idle");
        halted_cnt = 0;
        run_cycle(16'h4014, 8'h11, 1'b0, 0, "restart_trig");
        run_transfer(-1, "restart_xfer");
        run_idle(1, "restart_after");
        chk("restart_len", 32'(halted_cnt), 32'd513);

        // trigger cken coinciding with reset: reset wins
        @(negedge clk_in);
        cpu_a_in    = 16'h4014;
        cpu_d_in    = 8'h33;
        cpu_r_nw_in = 1'b0;
        cpu_cken_in = 1'b1;
        rst_in      = 1'b1;
        @(negedge clk_in);
        cpu_cken_in = 1'b0;
        rst_in      = 1'b0;
        cyc  = 0;
        trig = -1;
        halted_cnt = 0;
        run_idle(4, "rst_trig_idle");
        chk("rst_trig_len", 32'(halted_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- CPU-side initiator for the PPU register interface. The PPU register block only responds to bus cycles; this block generates them.
- It snoops CPU writes to $4014, halts the CPU, and copies 256 bytes from CPU page {val,00}–{val,FF} into the PPU's $2004 (OAMDATA) port, one read/write pair per byte.
- It sits in the CPU/memory-controller domain. The top level muxes its bus outputs over the CPU's while active_out=1.

Parameters:
- DMA_TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- OAM_DATA_ADDR, 16'h2004, PPU OAMDATA register address written each byte.

Ports:
- clk_in  in  1  50MHz system clock
- rst_in  in  1  reset; asynchronous, active-high
- cpu_cken_in  in  1  one-clk pulse marking the end of each CPU bus cycle; all state advances only on this pulse
- cpu_a_in  in  16  CPU address (snooped)
- cpu_d_in  in  8  CPU write data (snooped)
- cpu_r_nw_in  in  1  CPU read/not-write (snooped)
- mem_d_in  in  8  read data returned for the DMA's own read cycle; valid at cpu_cken_in
- active_out  out  1  DMA owns the CPU bus
- cpu_rdy_out  out  1  low = CPU halted
- a_out  out  16  DMA bus address
- d_out  out  8  DMA bus write data
- r_nw_out  out  1  DMA bus read/not-write

Behaviour:
- Reset (async, any state): go to IDLE and clear page, count, data latch and parity. Outputs reset to active_out=0, cpu_rdy_out=1, a_out=0, d_out=0, r_nw_out=1.
- Parity register q_par:
  - Toggles on every cpu_cken_in; reset 0.
  - It is the parity of the current CPU cycle; cycle 0 after reset is even.
- Outputs are Moore, decoded from registered state, so they change only on the clk after a cpu_cken_in.
- IDLE:
  - On cpu_cken_in with cpu_r_nw_in=0 and cpu_a_in==DMA_TRIG_ADDR: latch page<=cpu_d_in, cnt<=0, go to HALT.
  - A read of $4014 does not trigger.
- HALT: one dummy CPU cycle.
  - Outputs: cpu_rdy_out=0, active_out=1, a_out=0, r_nw_out=1.
  - On cken, go to ALIGN if the next cycle's parity is odd, otherwise go to READ.
- ALIGN: one extra dummy cycle with the same outputs as HALT; then go to READ. Every READ therefore lands on an even-parity cycle.
- READ:
  - Outputs: a_out={page,cnt}, r_nw_out=1.
  - On cken: data latch<=mem_d_in, go to WRITE.
- WRITE:
  - Outputs: a_out=OAM_DATA_ADDR, d_out=latch, r_nw_out=0.
  - On cken: if cnt==8'hFF go to IDLE, otherwise cnt<=cnt+1 and go to READ.
- Transfer length:
  - Trigger on an even cycle: 513 halted cycles (HALT + 512).
  - Trigger on an odd cycle: 514 halted cycles (HALT + ALIGN + 512).
- cpu_rdy_out and active_out stay deasserted/asserted across all non-IDLE states. They return to 1/0 the clk after the final WRITE cken.
- Boundary conditions:
  - cnt wraps after 8'hFF, and that wrap ends the transfer. The source address never crosses a page; for page FF the last byte comes from $FFFF.
  - Snooped bus activity while not IDLE (including further $4014 writes) is ignored.
  - cpu_cken_in low holds all state, so gaps between pulses are legal.
  - A trigger cken coinciding with rst_in: reset wins.
  - rst_in mid-transfer aborts immediately, and the CPU is released asynchronously.
  - Sprite OAM address auto-increment is the PPU's responsibility; this block never writes $2003.

Decomposition:
- Shared package: state encoding (IDLE, HALT, ALIGN, READ, WRITE), DMA_TRIG_ADDR, OAM_DATA_ADDR.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: rst_in asserted mid-transfer at byte 0x40 -> outputs go immediately to active=0, rdy=1, a=0, r_nw=1. A new $4014 write afterwards restarts from cnt=0.
- Even trigger: write 8'h02 to $4014 on cycle 10 -> rdy low for exactly 513 ckens. First read is a=$0200 on cycle 12, first write is a=$2004 on cycle 13, last write is on cycle 523.
- Odd trigger: write 8'h07 on cycle 11 -> rdy low for 514 ckens, with ALIGN on cycle 13. First read is a=$0700 on cycle 14.
- Data path: memory model returns byte = low address XOR 8'hA5, page 8'hFF -> the 256 writes carry d_out = i XOR 8'hA5 in order (i = 0..255). Last read a=$FFFF, then return to IDLE.
- Ignored events:
  - $4014 read -> no transfer.
  - A second $4014 write mid-transfer -> page unchanged, length unchanged.
  - cken held low for 20 clks mid-READ -> outputs frozen and no byte skipped.
